cpu_io_bridge: RTL

- Peripheral at the far end of the processor's data_in / data_out / interrupt pins; it plays the external-device role for the core.
- Inbound: host words are buffered in an RX FIFO. The head word is presented on cpu_data_in, and a one-cycle interrupt is raised per word awaiting the CPU.
- Outbound: words the CPU strobes out on data_out are captured in a TX FIFO and drained to the host with a valid/ready handshake.

---
 rtl/cpu_io_bridge.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cpu_io_bridge.sv
// cpu_io_bridge: external-device side of the core's data_in/data_out/interrupt pins.
// RX FIFO feeds the core with one interrupt per word; TX FIFO drains core writes to the host.
module cpu_io_bridge #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          host_rx_data,
  input  logic                       host_rx_valid,
  output logic                       host_rx_ready,
  output logic [DATA_W-1:0]          cpu_data_in,
  output logic                       interrupt,
  input  logic                       cpu_rd_ack,
  input  logic [DATA_W-1:0]          cpu_data_out,
  input  logic                       cpu_wr,
  output logic [DATA_W-1:0]          host_tx_data,
  output logic                       host_tx_valid,
  input  logic                       host_tx_ready,
  output logic [$clog2(DEPTH):0]     rx_count,
  output logic                       tx_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    WAIT_ACK
  } irq_state_t;

  irq_state_t state, state_nx;

  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [AW-1:0]     rx_wp, rx_rp, rx_rd_idx;
  logic [AW-1:0]     tx_wp, tx_rp;
  logic [CW-1:0]     rx_cnt, rx_cnt_nx, tx_cnt;
  logic [DATA_W-1:0] rx_head_nx;
  logic              rx_full, rx_empty, rx_push, rx_pop;
  logic              tx_full, tx_push, tx_pop, tx_drop;

  assign rx_full  = (rx_cnt == CW'(DEPTH));
  assign rx_empty = (rx_cnt == '0);
  assign tx_full  = (tx_cnt == CW'(DEPTH));

  assign host_rx_ready = reset & ~rx_full;
  assign rx_push = host_rx_valid & host_rx_ready;
  assign rx_pop  = cpu_rd_ack & ~rx_empty;
  assign rx_cnt_nx = rx_cnt + CW'(rx_push) - CW'(rx_pop);
  assign rx_count = rx_cnt;

  assign host_tx_valid = (tx_cnt != '0);
  assign host_tx_data  = host_tx_valid ? tx_mem[tx_rp] : '0;
  assign tx_pop  = host_tx_valid & host_tx_ready;
  assign tx_push = cpu_wr & (~tx_full | tx_pop);
  assign tx_drop = cpu_wr & tx_full & ~tx_pop;

  assign interrupt = (state == FIRE);

  // Next RX head, forwarding the incoming word when it lands at the new head.
  always_comb begin
    rx_rd_idx  = rx_pop ? rx_rp + AW'(1) : rx_rp;
    rx_head_nx = '0;
    if (rx_cnt_nx != '0) begin
      if (rx_push && (rx_rd_idx == rx_wp))
        rx_head_nx = host_rx_data;
      else
        rx_head_nx = rx_mem[rx_rd_idx];
    end
  end

  // FIFO storage; contents are don't-care while the matching count is zero.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= host_rx_data;
    if (tx_push) tx_mem[tx_wp] <= cpu_data_out;
  end

  // RX pointers, occupancy and registered head word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wp       <= '0;
      rx_rp       <= '0;
      rx_cnt      <= '0;
      cpu_data_in <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      rx_cnt      <= rx_cnt_nx;
      cpu_data_in <= rx_head_nx;
    end
  end

  // TX pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wp       <= '0;
      tx_rp       <= '0;
      tx_cnt      <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      if (tx_drop) tx_overflow <= 1'b1;
    end
  end

  // IRQ state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // IRQ next state: one pulse per word, re-armed only by a consuming pop.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (rx_cnt != '0) state_nx = FIRE;
      FIRE:     state_nx = WAIT_ACK;
      WAIT_ACK: if (rx_pop) state_nx = (rx_cnt_nx != '0) ? FIRE : IDLE;
      default:  state_nx = IDLE;
    endcase
  end

endmodule
